dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and a loader/debug master (port 1). Each request is latched and granted by round-robin, then replayed onto the memory port. Each transaction ends with a one-cycle acknowledge pulse. Port 0 uses `m0_req & ~m0_ack` as its pipeline stall.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store path (port 0) and a loader/debug master (port 1). A request
// is latched at grant (round-robin on ties), replayed onto the memory port
// for one write cycle or LAT read cycles, then finished with a one-cycle ack.
module dmem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;
  logic          gid_reg, gid_next;
  logic          we_reg, we_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic          mem_wen_reg, mem_wen_next;
  logic          mem_ren_reg, mem_ren_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic          m0_ack_reg, m0_ack_next;
  logic          m1_ack_reg, m1_ack_next;
  logic [DW-1:0] m0_rdata_reg, m0_rdata_next;
  logic [DW-1:0] m1_rdata_reg, m1_rdata_next;

  // On a tie the port not served last wins; otherwise the lone requester.
  logic          grant_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign grant_id  = (m0_req & m1_req) ? ~last_reg : m1_req;
  assign sel_we    = grant_id ? m1_we    : m0_we;
  assign sel_addr  = grant_id ? m1_addr  : m0_addr;
  assign sel_wdata = grant_id ? m1_wdata : m0_wdata;

  assign mem_wen   = mem_wen_reg;
  assign mem_ren   = mem_ren_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign m0_ack    = m0_ack_reg;
  assign m1_ack    = m1_ack_reg;
  assign m0_rdata  = m0_rdata_reg;
  assign m1_rdata  = m1_rdata_reg;
  assign busy      = (state_reg != IDLE);

  // Next-state and next-output logic; memory strobes are set one cycle ahead
  // so that they are registered and line up with the ACCESS state.
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    gid_next       = gid_reg;
    we_next        = we_reg;
    cnt_next       = cnt_reg;
    mem_wen_next   = 1'b0;
    mem_ren_next   = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    m0_ack_next    = 1'b0;
    m1_ack_next    = 1'b0;
    m0_rdata_next  = m0_rdata_reg;
    m1_rdata_next  = m1_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (m0_req | m1_req) begin
          gid_next       = grant_id;
          we_next        = sel_we;
          mem_addr_next  = sel_addr;
          mem_wdata_next = sel_wdata;
          cnt_next       = LAT_CNT;
          mem_wen_next   = sel_we;
          mem_ren_next   = ~sel_we;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_reg) begin
          m0_ack_next = ~gid_reg;
          m1_ack_next = gid_reg;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            // Last read cycle: capture memory data straight into the port.
            if (gid_reg) m1_rdata_next = mem_rdata;
            else         m0_rdata_next = mem_rdata;
            m0_ack_next = ~gid_reg;
            m1_ack_next = gid_reg;
            state_next  = DONE;
          end else begin
            mem_ren_next = 1'b1;
          end
        end
      end
      DONE: begin
        last_next  = gid_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      gid_reg       <= 1'b0;
      we_reg        <= 1'b0;
      cnt_reg       <= 3'd0;
      mem_wen_reg   <= 1'b0;
      mem_ren_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      m0_ack_reg    <= 1'b0;
      m1_ack_reg    <= 1'b0;
      m0_rdata_reg  <= '0;
      m1_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      gid_reg       <= gid_next;
      we_reg        <= we_next;
      cnt_reg       <= cnt_next;
      mem_wen_reg   <= mem_wen_next;
      mem_ren_reg   <= mem_ren_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      m0_ack_reg    <= m0_ack_next;
      m1_ack_reg    <= m1_ack_next;
      m0_rdata_reg  <= m0_rdata_next;
      m1_rdata_reg  <= m1_rdata_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances (LAT=1 and LAT=3), each with a
// small behavioural memory and a transaction-level reference model that is
// compared against every output on every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        m0_req   [2];
  logic        m0_we    [2];
  logic [31:0] m0_addr  [2];
  logic [31:0] m0_wdata [2];
  logic [31:0] m0_rdata [2];
  logic        m0_ack   [2];
  logic        m1_req   [2];
  logic        m1_we    [2];
  logic [31:0] m1_addr  [2];
  logic [31:0] m1_wdata [2];
  logic [31:0] m1_rdata [2];
  logic        m1_ack   [2];
  logic        mem_wen  [2];
  logic        mem_ren  [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        busy     [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LATV = (gi == 0) ? 1 : 3;

      dmem_arbiter #(.AW(32), .DW(32), .LAT(LATV)) u_dut (
        .clk      (clk),
        .rst      (rst[gi]),
        .m0_req   (m0_req[gi]),
        .m0_we    (m0_we[gi]),
        .m0_addr  (m0_addr[gi]),
        .m0_wdata (m0_wdata[gi]),
        .m0_rdata (m0_rdata[gi]),
        .m0_ack   (m0_ack[gi]),
        .m1_req   (m1_req[gi]),
        .m1_we    (m1_we[gi]),
        .m1_addr  (m1_addr[gi]),
        .m1_wdata (m1_wdata[gi]),
        .m1_rdata (m1_rdata[gi]),
        .m1_ack   (m1_ack[gi]),
        .mem_wen  (mem_wen[gi]),
        .mem_ren  (mem_ren[gi]),
        .mem_addr (mem_addr[gi]),
        .mem_wdata(mem_wdata[gi]),
        .mem_rdata(mem_rdata[gi]),
        .busy     (busy[gi])
      );

      // Memory: combinational read of the presented address, write on mem_wen.
      logic [31:0] bmem [256];
      initial begin
        for (int a = 0; a < 256; a++) bmem[a] = 32'h0;
        bmem[8'h20] = 32'h12345678;
        bmem[8'h30] = 32'hA5A5A5A5;
      end
      always @(posedge clk) if (mem_wen[gi]) bmem[mem_addr[gi][7:0]] <= mem_wdata[gi];
      assign mem_rdata[gi] = bmem[mem_addr[gi][7:0]];

      // Reference model: one transaction at a time, timed by its offset k
      // from the sample cycle; strobes on k=1..dur, ack on k=dur+1.
      bit          act;
      int          k, dur, port, last;
      bit          twe;
      logic [31:0] taddr, twdata, e_addr, e_wdata;
      logic [31:0] e_rd [2];
      logic [31:0] shadow [256];

      initial begin
        act = 0; k = 0; dur = 1; port = 0; last = 1; twe = 0;
        taddr = 0; twdata = 0; e_addr = 0; e_wdata = 0; e_rd[0] = 0; e_rd[1] = 0;
        for (int a = 0; a < 256; a++) shadow[a] = 32'h0;
        shadow[8'h20] = 32'h12345678;
        shadow[8'h30] = 32'hA5A5A5A5;
        forever begin
          @(posedge clk);
          if (rst[gi]) begin
            act = 0; k = 0; last = 1; e_addr = 0; e_wdata = 0; e_rd[0] = 0; e_rd[1] = 0;
          end else if (!act) begin
            if (m0_req[gi] || m1_req[gi]) begin
              if (m0_req[gi] && m1_req[gi]) port = (last == 0) ? 1 : 0;
              else port = m0_req[gi] ? 0 : 1;
              twe    = (port == 0) ? m0_we[gi]    : m1_we[gi];
              taddr  = (port == 0) ? m0_addr[gi]  : m1_addr[gi];
              twdata = (port == 0) ? m0_wdata[gi] : m1_wdata[gi];
              act = 1; k = 1; dur = twe ? 1 : LATV;
              e_addr = taddr; e_wdata = twdata;
            end
          end else begin
            k++;
            if (k == dur + 1) begin
              if (twe) shadow[taddr[7:0]] = twdata;
              else     e_rd[port] = shadow[taddr[7:0]];
            end
            if (k == dur + 2) begin
              act = 0; last = port;
            end
          end
          #2;
          chkb($sformatf("L%0d mem_wen", LATV), mem_wen[gi], act && twe && k <= dur);
          chkb($sformatf("L%0d mem_ren", LATV), mem_ren[gi], act && !twe && k <= dur);
          chkb($sformatf("L%0d m0_ack", LATV), m0_ack[gi], act && k == dur + 1 && port == 0);
          chkb($sformatf("L%0d m1_ack", LATV), m1_ack[gi], act && k == dur + 1 && port == 1);
          chkb($sformatf("L%0d busy", LATV), busy[gi], act);
          chk($sformatf("L%0d mem_addr", LATV), mem_addr[gi], e_addr);
          chk($sformatf("L%0d mem_wdata", LATV), mem_wdata[gi], e_wdata);
          chk($sformatf("L%0d m0_rdata", LATV), m0_rdata[gi], e_rd[0]);
          chk($sformatf("L%0d m1_rdata", LATV), m1_rdata[gi], e_rd[1]);
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input int p, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req[i] = r; m0_we[i] = w; m0_addr[i] = a; m0_wdata[i] = d;
    end else begin
      m1_req[i] = r; m1_we[i] = w; m1_addr[i] = a; m1_wdata[i] = d;
    end
  endtask

  function automatic logic ack_of(input int i, input int p);
    return (p == 0) ? m0_ack[i] : m1_ack[i];
  endfunction

  function automatic logic [31:0] rdata_of(input int i, input int p);
    return (p == 0) ? m0_rdata[i] : m1_rdata[i];
  endfunction

  // Waits (bounded) for port p's ack; n is the cycle index of the ack.
  task automatic wait_ack(input int i, input int p, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_of(i, p) && n < bound);
    chkb($sformatf("L%0d p%0d ack seen", lat_of(i), p), ack_of(i, p), 1'b1);
    $display("[TB] L%0d port%0d ack after %0d cycles, rdata=%h", lat_of(i), p, n, rdata_of(i, p));
  endtask

  // Asserts reset between edges (after that cycle's compare) for one edge.
  task automatic pulse_reset(input int i);
    @(posedge clk);
    #3 rst[i] = 1'b1;
    @(posedge clk);
    #1 rst[i] = 1'b0;
  endtask

  task automatic test_lat1();
    int n, got, prev0, prev1;
    logic [3:0] ord;
    // Port 0 write, cycle by cycle.
    setreq(0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    tick();
    chkb("wr c1 mem_wen", mem_wen[0], 1'b1);
    chk("wr c1 mem_addr", mem_addr[0], 32'h10);
    chk("wr c1 mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    chkb("wr c1 m0_ack", m0_ack[0], 1'b0);
    tick();
    chkb("wr c2 m0_ack", m0_ack[0], 1'b1);
    chkb("wr c2 mem_wen", mem_wen[0], 1'b0);
    chkb("wr c2 busy", busy[0], 1'b1);
    setreq(0, 0, 0, 0, 32'h0, 32'h0);
    $display("[TB] L1 port0 write [10]=deadbeef ack in cycle 2");
    tick();
    chkb("wr c3 busy", busy[0], 1'b0);
    // Port 1 reads it back.
    setreq(0, 1, 1, 0, 32'h10, 32'h0);
    wait_ack(0, 1, 20, n);
    chk("rd ack cycle", n, 2);
    chk("rd m1_rdata", m1_rdata[0], 32'hDEADBEEF);
    setreq(0, 1, 0, 0, 32'h0, 32'h0);
    tick();

    // Tie arbitration from reset.
    pulse_reset(0);
    setreq(0, 0, 1, 1, 32'h40, 32'h1);
    setreq(0, 1, 1, 0, 32'h40, 32'h0);
    got = 0; prev0 = 0; prev1 = 0; ord = 4'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      chkb("tie ack overlap", m0_ack[0] & m1_ack[0], 1'b0);
      chkb("tie m0_ack pulse", m0_ack[0] & prev0[0], 1'b0);
      chkb("tie m1_ack pulse", m1_ack[0] & prev1[0], 1'b0);
      prev0 = int'(m0_ack[0]);
      prev1 = int'(m1_ack[0]);
      if (m0_ack[0] || m1_ack[0]) begin
        ord[got] = m1_ack[0];
        $display("[TB] L1 tie grant %0d -> port%0d", got, m1_ack[0]);
        got++;
      end
    end
    setreq(0, 0, 0, 0, 32'h0, 32'h0);
    setreq(0, 1, 0, 0, 32'h0, 32'h0);
    chk("tie ack count", got, 4);
    chk("tie order", {28'h0, ord}, 32'hA);
    chk("tie m1_rdata", m1_rdata[0], 32'h1);
    tick();

    // Reset mid-run during a port 1 read.
    setreq(0, 1, 1, 0, 32'h40, 32'h0);
    tick();
    chkb("rst pre mem_ren", mem_ren[0], 1'b1);
    #2 rst[0] = 1'b1;
    setreq(0, 1, 0, 0, 32'h0, 32'h0);
    #1;
    chkb("rst mem_ren", mem_ren[0], 1'b0);
    chkb("rst busy", busy[0], 1'b0);
    chk("rst mem_addr", mem_addr[0], 32'h0);
    chk("rst mem_wdata", mem_wdata[0], 32'h0);
    chk("rst m1_rdata", m1_rdata[0], 32'h0);
    chkb("rst m1_ack", m1_ack[0], 1'b0);
    $display("[TB] L1 reset mid-run");
    @(posedge clk);
    #1 rst[0] = 1'b0;
    repeat (4) tick();
    chkb("post-rst busy", busy[0], 1'b0);
    chkb("post-rst mem_ren", mem_ren[0], 1'b0);
  endtask

  task automatic test_lat3();
    int n, acks;
    // Port 0 LAT=3 read of 0x20.
    setreq(1, 0, 1, 0, 32'h20, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chkb($sformatf("l3 c%0d mem_ren", c), mem_ren[1], c <= 3);
      chkb($sformatf("l3 c%0d mem_wen", c), mem_wen[1], 1'b0);
      chkb($sformatf("l3 c%0d m0_ack", c), m0_ack[1], c == 4);
    end
    chk("l3 m0_rdata", m0_rdata[1], 32'h12345678);
    setreq(1, 0, 0, 0, 32'h0, 32'h0);
    $display("[TB] L3 port0 read [20] ack in cycle 4, rdata=%h", m0_rdata[1]);
    tick();
    // A following write must leave m0_rdata alone.
    setreq(1, 0, 1, 1, 32'h24, 32'h55);
    wait_ack(1, 0, 20, n);
    chk("l3 wr ack cycle", n, 2);
    setreq(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("l3 wr keeps m0_rdata", m0_rdata[1], 32'h12345678);

    // Reset in cycle 1 of a port 1 read; port 1 keeps requesting.
    setreq(1, 1, 1, 0, 32'h20, 32'h0);
    tick();
    chkb("ra c1 mem_ren", mem_ren[1], 1'b1);
    #2 rst[1] = 1'b1;
    #1;
    chkb("ra mem_ren drop", mem_ren[1], 1'b0);
    chkb("ra m1_ack", m1_ack[1], 1'b0);
    chkb("ra busy", busy[1], 1'b0);
    @(posedge clk);
    #1 rst[1] = 1'b0;
    setreq(1, 0, 1, 1, 32'h28, 32'h77);
    wait_ack(1, 0, 20, n);
    chk("ra p0 ack cycle", n, 2);
    chkb("ra p0 first", m1_ack[1], 1'b0);
    setreq(1, 0, 0, 0, 32'h0, 32'h0);
    wait_ack(1, 1, 20, n);
    chk("ra p1 ack cycle", n, 5);
    chk("ra p1 rdata", m1_rdata[1], 32'h12345678);
    setreq(1, 1, 0, 0, 32'h0, 32'h0);
    tick();

    // Early req drop with changed address.
    setreq(1, 0, 1, 0, 32'h30, 32'h0);
    tick();
    setreq(1, 0, 0, 0, 32'h99, 32'h0);
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("drop c%0d mem_addr", c), mem_addr[1], 32'h30);
      if (m0_ack[1]) acks++;
      tick();
    end
    chk("drop ack count", acks, 1);
    chk("drop m0_rdata", m0_rdata[1], 32'hA5A5A5A5);
    $display("[TB] L3 port0 read [30] after early drop, rdata=%h", m0_rdata[1]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      setreq(i, 0, 0, 0, 32'h0, 32'h0);
      setreq(i, 1, 0, 0, 32'h0, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chkb("init busy", busy[0], 1'b0);
    chkb("init m0_ack", m0_ack[0], 1'b0);
    chk("init mem_addr", mem_addr[0], 32'h0);
    chk("init m0_rdata", m0_rdata[0], 32'h0);
    tick();
    test_lat1();
    test_lat3();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
